// File: rtl/alu8_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: ALU op codes and FSM states.
package alu8_seq_pkg;

  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_THRU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu8_seq_if.sv
// Bundle of request, ALU-side and result/flag signals of the alu8_seq sequencer.
interface alu8_seq_if #(
  parameter int unsigned MAX_BYTES = 4
);
  localparam int unsigned IDX_W = $clog2(MAX_BYTES);
  localparam int unsigned LEN_W = $clog2(MAX_BYTES + 1);

  logic             start;
  logic [2:0]       op;
  logic [LEN_W-1:0] len;
  logic             use_carry;
  logic             a_msb;
  logic             b_msb;
  logic [2:0]       alu_sel;
  logic             alu_cin;
  logic [7:0]       alu_out;
  logic             alu_cout;
  logic [IDX_W-1:0] byte_idx;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_data;
  logic             c_flag;
  logic             z_flag;
  logic             v_flag;

  modport slave (
    input  start, op, len, use_carry, a_msb, b_msb, alu_out, alu_cout, rd_idx,
    output alu_sel, alu_cin, byte_idx, busy, done, rd_data, c_flag, z_flag, v_flag
  );

  modport master (
    output start, op, len, use_carry, a_msb, b_msb, alu_out, alu_cout, rd_idx,
    input  alu_sel, alu_cin, byte_idx, busy, done, rd_data, c_flag, z_flag, v_flag
  );

endinterface

// File: rtl/alu8_seq.sv
// Multi-byte ALU sequencer with carry chaining, C/Z flags and result buffer.
// Optional signed-overflow flag enabled by defining ALU8_SEQ_OVF_EN.
module alu8_seq
  import alu8_seq_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 4
) (
  input logic      clk,
  input logic      rst,
  alu8_seq_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(MAX_BYTES);
  localparam int unsigned LEN_W = $clog2(MAX_BYTES + 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic             r_uc;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last;
  logic             r_cy;
  logic             r_zacc;
  logic             r_c;
  logic             r_z;
  logic [7:0]       r_buf [MAX_BYTES];

  logic             w_accept;
  logic             w_last_byte;
  logic             w_byte_zero;
  logic [LEN_W-1:0] w_len_eff;
  logic [IDX_W-1:0] w_last;

  always_comb begin
    if (bus.len == '0)
      w_len_eff = LEN_W'(1);
    else if (bus.len > LEN_W'(MAX_BYTES))
      w_len_eff = LEN_W'(MAX_BYTES);
    else
      w_len_eff = bus.len;
  end

  assign w_last      = IDX_W'(w_len_eff - LEN_W'(1));
  assign w_accept    = (r_state == S_IDLE) && bus.start && (bus.op[2:1] != 2'b00);
  assign w_last_byte = (r_state == S_RUN) && (r_idx == r_last);
  assign w_byte_zero = (bus.alu_out == 8'h00);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    bus.alu_sel = OP_THRU;
    bus.alu_cin = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        bus.busy    = 1'b1;
        bus.alu_sel = r_op;
        // Byte 0 seeds the chain: stored carry for ADC/SBC, forced 1 for plain SUB.
        if (r_idx == '0)
          bus.alu_cin = r_uc ? r_c : (r_op == OP_SUB);
        else
          bus.alu_cin = r_cy;
        if (r_idx == r_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_THRU;
      r_uc   <= 1'b0;
      r_idx  <= '0;
      r_last <= '0;
      r_cy   <= 1'b0;
      r_zacc <= 1'b0;
      r_c    <= 1'b0;
      r_z    <= 1'b0;
      for (int unsigned i = 0; i < MAX_BYTES; i++) r_buf[i] <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.op;
        r_uc   <= bus.use_carry;
        r_last <= w_last;
        r_idx  <= '0;
        r_zacc <= 1'b1;
        for (int unsigned i = 0; i < MAX_BYTES; i++)
          if (LEN_W'(i) >= w_len_eff) r_buf[i] <= '0;
      end
      if (r_state == S_RUN) begin
        r_buf[r_idx] <= bus.alu_out;
        r_cy         <= bus.alu_cout;
        r_zacc       <= r_zacc & w_byte_zero;
        if (w_last_byte) begin
          r_c   <= bus.alu_cout;
          r_z   <= r_zacc & w_byte_zero;
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

`ifdef ALU8_SEQ_OVF_EN
  logic r_v;
  logic w_v;

  always_comb begin
    w_v = 1'b0;
    case (r_op)
      OP_ADD:  w_v = (bus.a_msb == bus.b_msb) && (bus.alu_out[7] != bus.a_msb);
      OP_SUB:  w_v = (bus.a_msb != bus.b_msb) && (bus.alu_out[7] != bus.a_msb);
      default: w_v = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_v <= 1'b0;
    else if (w_last_byte)
      r_v <= w_v;
  end

  assign bus.v_flag = r_v;
`else
  assign bus.v_flag = 1'b0;
`endif

  assign bus.byte_idx = r_idx;
  assign bus.c_flag   = r_c;
  assign bus.z_flag   = r_z;
  assign bus.rd_data  = r_buf[bus.rd_idx];

endmodule

// File: tb/tb_alu8_seq.sv
// Directed self-checking bench for alu8_seq; the bench plays the 8-bit ALU.
module tb_alu8_seq;
  import alu8_seq_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n;
  int   seen;
  logic exp_v;

  logic [7:0] ta [4];
  logic [7:0] tb_b [4];
  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [8:0] sum;

  alu8_seq_if #(.MAX_BYTES(4)) bus ();

  alu8_seq #(.MAX_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    a_byte = ta[bus.byte_idx];
    b_byte = tb_b[bus.byte_idx];
    sum    = '0;
    case (bus.alu_sel)
      OP_SUB:  sum = {1'b0, a_byte} + {1'b0, ~b_byte} + {8'h00, bus.alu_cin};
      OP_ADD:  sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'h00, bus.alu_cin};
      OP_XOR:  sum = {1'b0, a_byte ^ b_byte};
      OP_OR:   sum = {1'b0, a_byte | b_byte};
      OP_AND:  sum = {1'b0, a_byte & b_byte};
      default: sum = {1'b0, a_byte};
    endcase
    bus.alu_out  = sum[7:0];
    bus.alu_cout = sum[8];
    bus.a_msb    = a_byte[7];
    bus.b_msb    = b_byte[7];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    bus.rd_idx = idx;
    #1;
    chk(tag, {24'h0, bus.rd_data}, {24'h0, exp});
  endtask

  task automatic do_start(input logic [2:0] op, input logic [2:0] len, input logic uc);
    @(negedge clk);
    bus.op        = op;
    bus.len       = len;
    bus.use_carry = uc;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int cnt);
    cnt = first;
    while (bus.done !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = OP_THRU; bus.len = '0; bus.use_carry = 1'b0; bus.rd_idx = '0;
    ta   = '{8'h00, 8'h00, 8'h00, 8'h00};
    tb_b = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_c", bus.c_flag, 1'b0);
    chk("rst_z", bus.z_flag, 1'b0);
    chk("rst_v", bus.v_flag, 1'b0);
    chk("rst_idx", bus.byte_idx, 2'd0);
    for (int i = 0; i < 4; i++) rd_chk("rst_rd", 2'(i), 8'h00);

    // ADD 0x12FF + 0x0001
    ta   = '{8'hFF, 8'h12, 8'h00, 8'h00};
    tb_b = '{8'h01, 8'h00, 8'h00, 8'h00};
    do_start(OP_ADD, 3'd2, 1'b0);
    chk("add_busy", bus.busy, 1'b1);
    chk("add_sel", bus.alu_sel, OP_ADD);
    chk("add_idx0", bus.byte_idx, 2'd0);
    chk("add_cin0", bus.alu_cin, 1'b0);
    @(negedge clk);
    chk("add_idx1", bus.byte_idx, 2'd1);
    chk("add_cin1", bus.alu_cin, 1'b1);
    @(negedge clk);
    chk("add_done", bus.done, 1'b1);
    chk("add_busy_done", bus.busy, 1'b0);
    rd_chk("add_rd0", 2'd0, 8'h00);
    rd_chk("add_rd1", 2'd1, 8'h13);
    rd_chk("add_rd2", 2'd2, 8'h00);
    chk("add_c", bus.c_flag, 1'b0);
    chk("add_z", bus.z_flag, 1'b0);
    chk("add_v", bus.v_flag, 1'b0);
    @(negedge clk);
    chk("add_done_pulse", bus.done, 1'b0);

    // SUB 0x05 - 0x05
    ta   = '{8'h05, 8'h00, 8'h00, 8'h00};
    tb_b = '{8'h05, 8'h00, 8'h00, 8'h00};
    do_start(OP_SUB, 3'd1, 1'b0);
    chk("sub_cin0", bus.alu_cin, 1'b1);
    wait_done(1, n);
    chk("sub_cycles", n, 2);
    rd_chk("sub_rd0", 2'd0, 8'h00);
    rd_chk("sub_rd1", 2'd1, 8'h00);
    chk("sub_c", bus.c_flag, 1'b1);
    chk("sub_z", bus.z_flag, 1'b1);

    // ADC 0x01 + 0x01 with carry in from C=1
    ta   = '{8'h01, 8'h00, 8'h00, 8'h00};
    tb_b = '{8'h01, 8'h00, 8'h00, 8'h00};
    do_start(OP_ADD, 3'd1, 1'b1);
    chk("adc_cin0", bus.alu_cin, 1'b1);
    wait_done(1, n);
    chk("adc_cycles", n, 2);
    rd_chk("adc_rd0", 2'd0, 8'h03);
    chk("adc_c", bus.c_flag, 1'b0);
    chk("adc_z", bus.z_flag, 1'b0);

    // Illegal op is ignored
    do_start(3'b001, 3'd2, 1'b0);
    chk("rej_busy", bus.busy, 1'b0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("rej_activity", seen, 0);
    rd_chk("rej_rd0", 2'd0, 8'h03);

    // OR over 4 bytes with a start attempt mid-run
    ta   = '{8'h10, 8'h20, 8'h30, 8'h40};
    tb_b = '{8'h01, 8'h01, 8'h01, 8'h01};
    do_start(OP_OR, 3'd4, 1'b0);
    bus.start = 1'b1;
    bus.op    = OP_SUB;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_sel_kept", bus.alu_sel, OP_OR);
    wait_done(2, n);
    chk("or_cycles", n, 5);
    rd_chk("or_rd0", 2'd0, 8'h11);
    rd_chk("or_rd1", 2'd1, 8'h21);
    rd_chk("or_rd2", 2'd2, 8'h31);
    rd_chk("or_rd3", 2'd3, 8'h41);
    chk("or_c", bus.c_flag, 1'b0);
    chk("or_z", bus.z_flag, 1'b0);

    // AND with len=0 is a single byte; upper bytes cleared
    ta   = '{8'h0F, 8'hFF, 8'hFF, 8'hFF};
    tb_b = '{8'hF0, 8'hFF, 8'hFF, 8'hFF};
    do_start(OP_AND, 3'd0, 1'b0);
    wait_done(1, n);
    chk("len0_cycles", n, 2);
    rd_chk("len0_rd0", 2'd0, 8'h00);
    rd_chk("len0_rd1", 2'd1, 8'h00);
    rd_chk("len0_rd3", 2'd3, 8'h00);
    chk("len0_z", bus.z_flag, 1'b1);
    chk("len0_c", bus.c_flag, 1'b0);

    // Reset in the second RUN cycle of a 4-byte op
    ta   = '{8'h01, 8'h02, 8'h03, 8'h04};
    tb_b = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_start(OP_ADD, 3'd4, 1'b0);
    @(negedge clk);
    chk("mid_idx1", bus.byte_idx, 2'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_idx", bus.byte_idx, 2'd0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk("mid_no_done", seen, 0);
    chk("mid_z", bus.z_flag, 1'b0);
    chk("mid_c", bus.c_flag, 1'b0);
    rd_chk("mid_rd0", 2'd0, 8'h00);

    // THRU with len=7 clamps to 4 bytes
    ta   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tb_b = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_start(OP_THRU, 3'd7, 1'b0);
    wait_done(1, n);
    chk("len7_cycles", n, 5);
    rd_chk("len7_rd0", 2'd0, 8'hAA);
    rd_chk("len7_rd3", 2'd3, 8'hDD);
    chk("len7_c", bus.c_flag, 1'b0);

`ifdef ALU8_SEQ_OVF_EN
    exp_v = 1'b1;
`else
    exp_v = 1'b0;
`endif

    // ADD 0x7F + 0x01 -> 0x80
    ta   = '{8'h7F, 8'h00, 8'h00, 8'h00};
    tb_b = '{8'h01, 8'h00, 8'h00, 8'h00};
    do_start(OP_ADD, 3'd1, 1'b0);
    wait_done(1, n);
    rd_chk("ovf_add_rd", 2'd0, 8'h80);
    chk("ovf_add_v", bus.v_flag, exp_v);
    chk("ovf_add_c", bus.c_flag, 1'b0);

    // SUB 0x80 - 0x01 -> 0x7F
    ta   = '{8'h80, 8'h00, 8'h00, 8'h00};
    tb_b = '{8'h01, 8'h00, 8'h00, 8'h00};
    do_start(OP_SUB, 3'd1, 1'b0);
    wait_done(1, n);
    rd_chk("ovf_sub_rd", 2'd0, 8'h7F);
    chk("ovf_sub_v", bus.v_flag, exp_v);
    chk("ovf_sub_c", bus.c_flag, 1'b1);

    // Logic op clears V
    do_start(OP_XOR, 3'd1, 1'b0);
    wait_done(1, n);
    rd_chk("xor_rd", 2'd0, 8'h81);
    chk("xor_v", bus.v_flag, 1'b0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu8_seq.md
Name: alu8_seq

Overview:
- Multi-byte operation sequencer and flag/result register directly upstream and downstream of the 8-bit ALU.
- Drives the ALU's op select and carry-in, and steps a byte index so operand muxes present byte k.
- Captures each ALU result byte and carry-out, chaining the carry into the next byte.
- Holds the C, Z (and optional V) flags and an N-byte result buffer for the register-file write-back.

Parameters:
- MAX_BYTES, 4, maximum operand length in bytes.
- IDX_W, $clog2(MAX_BYTES), byte-index width (localparam).
- LEN_W, $clog2(MAX_BYTES+1), length field width (localparam).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation.
- op  in  3  ALU op code: 010 SUB, 011 ADD, 100 XOR, 101 OR, 110 AND, 111 THRU.
- len  in  LEN_W  operand length in bytes.
- use_carry  in  1  first byte takes carry-in from c_flag (ADC/SBC).
- a_msb  in  1  bit 7 of the current A operand byte (used only with the optional feature).
- b_msb  in  1  bit 7 of the current B operand byte (used only with the optional feature).
- alu_sel  out  3  to ALU sel_in.
- alu_cin  out  1  to ALU carry_in.
- alu_out  in  8  from ALU out.
- alu_cout  in  1  from ALU carry_out.
- byte_idx  out  IDX_W  operand/result byte currently processed.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- rd_idx  in  IDX_W  result buffer read select.
- rd_data  out  8  combinational read of result byte rd_idx.
- c_flag  out  1  carry flag.
- z_flag  out  1  zero flag.
- v_flag  out  1  signed overflow flag.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE.
  - busy=0, done=0, byte_idx=0.
  - c_flag=0, z_flag=0, v_flag=0.
  - Result buffer all 0x00.
  - Reset mid-operation aborts it: no done pulse, flags not updated.
- States: IDLE, RUN, DONE.
- IDLE:
  - alu_sel=111, alu_cin=0, busy=0.
  - start=1 with op in {010..111} latches op, use_carry and effective length, then goes to RUN.
  - start=1 with op 000/001 is ignored; the block stays in IDLE.
- Effective length:
  - len=0 is treated as 1.
  - len>MAX_BYTES is clamped to MAX_BYTES.
- RUN, one byte per cycle, byte_idx=0..L-1:
  - busy=1, alu_sel=latched op.
  - alu_cin on byte 0:
    - use_carry=1: c_flag.
    - use_carry=0, SUB: 1.
    - Otherwise: 0.
  - alu_cin on bytes >0: the alu_cout registered from the previous byte.
  - Each cycle: buffer[byte_idx] <= alu_out; the running zero accumulator is ANDed with (alu_out==0).
  - Bytes at index >=L in the buffer are cleared to 0 at start acceptance.
- Last byte (byte_idx=L-1): at the edge, c_flag <= alu_cout, z_flag <= accumulated zero including this byte; go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Flags and buffer are valid.
  - start is ignored in DONE; the state unconditionally returns to IDLE.
- Latency: an L-byte operation shows done L+1 cycles after the start-accept edge.
- start while busy is ignored; the latched op is unaffected.
- Logic ops and THRU write c_flag with alu_cout (0 for these ops).
- c_flag meaning for SUB: 1 = no borrow.
- Flags and buffer hold their values until the next completion or reset.

Optional Feature:
- Macro: ALU8_SEQ_OVF_EN.
- Defined: on the last byte, v_flag is computed from a_msb, b_msb and r=alu_out[7]:
  - ADD: (a==b)&&(r!=a).
  - SUB (A−B): (a!=b)&&(r!=a).
  - Logic/THRU: 0.
  - v_flag updates at the same edge as C/Z.
- Undefined: v_flag is tied to 0; a_msb and b_msb are unused.
- The port list is identical in both builds.

Decomposition:
- Shared package holds:
  - ALU op-code constants (SUB, ADD, XOR, OR, AND, THRU) shared with the ALU and the decoder.
  - FSM state encoding.
- No sub-module: result buffer and FSM stay inline.

Test Plan:
- Reset: assert rst for 2 cycles → busy=0, done=0, all flags 0, rd_data=0x00 for every rd_idx.
- ADD 0x12FF+0x0001, len=2, use_carry=0:
  - byte0: alu_cin=0 → result 0x00, carry 1.
  - byte1: alu_cin=1 → result 0x13.
  - Buffer reads 0x00,0x13; C=0, Z=0; done 3 cycles after accept.
- SUB 0x05−0x05, len=1 → alu_cin=1, result 0x00, C=1, Z=1; then ADC 0x01+0x01 with use_carry=1 → alu_cin=1, result 0x03, C=0, Z=0.
- Start rejection and length handling:
  - start with op=001 → stays IDLE, no done.
  - start during RUN → ignored, original result intact.
  - len=0 → 1 byte.
  - len=7 → 4 bytes processed.
- rst asserted in the 2nd RUN cycle of a 4-byte op → IDLE next cycle, no done pulse, flags and buffer at 0.
- Overflow, build with ALU8_SEQ_OVF_EN:
  - ADD 0x7F+0x01 → V=1.
  - SUB 0x80−0x01 → V=1.
  - Without the macro → V=0.
